// File: rtl/alu_issue_sched.sv
// Round-robin per-warp issue scheduler feeding the ALU through a single-entry output register.
// A warp that issues a branch is held off until branch control reports the branch resolved.
module alu_issue_sched #(
    parameter int NUM_WARPS = 4,
    parameter int DATAW     = 128,
    parameter int NW_BITS   = $clog2(NUM_WARPS)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_WARPS-1:0]       req_valid,
    input  logic [NUM_WARPS-1:0]       req_is_br,
    input  logic [NUM_WARPS*DATAW-1:0] req_data,
    output logic [NUM_WARPS-1:0]       req_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NW_BITS-1:0]         out_wid,
    output logic                       out_is_br,
    output logic [DATAW-1:0]           out_data,
    input  logic                       br_valid,
    input  logic [NW_BITS-1:0]         br_wid,
    output logic [NUM_WARPS-1:0]       br_pend,
    output logic                       idle
);

    logic [NW_BITS-1:0]   rr_ptr;
    logic [NUM_WARPS-1:0] eligible;
    logic                 load_en;
    logic                 grant_vld_p0;
    logic [NW_BITS-1:0]   grant_wid_p0;
    logic                 grant_br_p0;
    logic [DATAW-1:0]     grant_data_p0;
    logic [NUM_WARPS-1:0] pend_nxt;

    assign eligible = req_valid & ~br_pend;
    assign load_en  = ~out_valid | out_ready;
    assign idle     = ~out_valid & ~|br_pend;

    // Scan starting at rr_ptr; NUM_WARPS is a power of two so the index wraps for free.
    always_comb begin
        logic [NW_BITS-1:0] idx;
        idx          = '0;
        grant_vld_p0 = 1'b0;
        grant_wid_p0 = '0;
        if (load_en) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                idx = rr_ptr + NW_BITS'(i);
                if (!grant_vld_p0 && eligible[idx]) begin
                    grant_vld_p0 = 1'b1;
                    grant_wid_p0 = idx;
                end
            end
        end
    end

    always_comb begin
        req_ready     = '0;
        grant_br_p0   = req_is_br[grant_wid_p0];
        grant_data_p0 = req_data[grant_wid_p0*DATAW +: DATAW];
        if (grant_vld_p0) begin
            req_ready = NUM_WARPS'(1) << grant_wid_p0;
        end
    end

    // Clear is applied first so a same-warp set in the same cycle wins.
    always_comb begin
        pend_nxt = br_pend;
        if (br_valid) begin
            pend_nxt[br_wid] = 1'b0;
        end
        if (grant_vld_p0 && grant_br_p0) begin
            pend_nxt[grant_wid_p0] = 1'b1;
        end
    end

    // ---- p0 -> output stage boundary ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_wid   <= '0;
            out_is_br <= 1'b0;
            out_data  <= '0;
            br_pend   <= '0;
            rr_ptr    <= '0;
        end else begin
            br_pend <= pend_nxt;
            if (load_en) begin
                out_valid <= grant_vld_p0;
            end
            if (grant_vld_p0) begin
                out_wid   <= grant_wid_p0;
                out_is_br <= grant_br_p0;
                out_data  <= grant_data_p0;
                rr_ptr    <= grant_wid_p0 + NW_BITS'(1);
            end
        end
    end

endmodule

// File: doc/alu_issue_sched.md
Name: alu_issue_sched

Overview:
Per-warp issue scheduler in front of the ALU unit. It selects one ALU request per cycle from NUM_WARPS per-warp queues using round-robin, and registers the selection into a single-entry output stage that drives the ALU request interface. It blocks a warp after it issues a branch until the branch-control resolution for that warp returns, so at most one unresolved branch exists per warp.

Parameters:
NUM_WARPS, 4, number of requesting warps (power of 2, ≥2)
DATAW, 128, opaque request payload width (uuid/PC/rs data/op fields), passed through untouched
NW_BITS, $clog2(NUM_WARPS), warp id width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_WARPS  per-warp request valid
req_is_br  in  NUM_WARPS  per-warp request is a branch/jump op
req_data  in  NUM_WARPS*DATAW  per-warp payload, warp w at [w*DATAW +: DATAW]
req_ready  out  NUM_WARPS  per-warp accept (one-hot or zero)
out_valid  out  1  request to ALU valid
out_ready  in  1  ALU accepts
out_wid  out  NW_BITS  warp id of the output request
out_is_br  out  1  output request is a branch
out_data  out  DATAW  payload of the output request
br_valid  in  1  branch resolved (from branch control)
br_wid  in  NW_BITS  warp whose branch resolved
br_pend  out  NUM_WARPS  per-warp unresolved-branch flags
idle  out  1  ~out_valid & ~|br_pend

Behaviour:
- Reset: the async assert of reset_n=0 clears out_valid, out_wid, out_is_br, out_data, br_pend, and rr_ptr to 0. Outputs are valid at the first clk edge after deassertion. A reset during a stalled output drops the held request with no replay.
- eligible[w] = req_valid[w] & ~br_pend[w].
- load_en = ~out_valid | out_ready.
- Grant (combinational): when load_en and |eligible, g is the first eligible warp scanning rr_ptr, rr_ptr+1, … modulo NUM_WARPS. req_ready[g]=1 and all other bits are 0. With no grant, req_ready=0.
- req_ready depends combinationally on out_ready. There is no combinational path from req_valid of warp w to req_ready of the same warp other than through the grant.
- On a grant, at the next edge:
  - out_valid←1, out_wid←g, out_is_br←req_is_br[g], out_data←req_data[g].
  - rr_ptr←g+1, wrapping NUM_WARPS-1→0.
- On load_en with no grant: out_valid←0, and the other output fields keep their values. rr_ptr is unchanged.
- While out_valid & ~out_ready, out_* are held stable and req_ready=0.
- Latency: request to out_valid is 1 cycle. Throughput is 1 request/cycle with out_ready held at 1.
- Branch blocking:
  - A grant with req_is_br[g]=1 sets br_pend[g] at the same edge as the load.
  - br_valid clears br_pend[br_wid].
  - Clearing a warp that is not pending is a no-op.
  - If a set and a clear hit the same warp in one cycle, set wins. This is only possible for a stray clear.
  - Set and clear on different warps in the same cycle both apply.
  - A branch issued at edge N becomes eligible again no earlier than the cycle after br_valid.
- Non-branch requests from a warp with br_pend=1 are also blocked, which enforces in-order issue per warp.
- No combinational path exists from br_valid to req_ready. The cleared flag is effective from the next cycle.

Test Plan:
- Fairness: NUM_WARPS=4, all req_valid=1, is_br=0, out_ready=1 → out_wid sequence 0,1,2,3,0,1 on consecutive cycles, with exactly one req_ready bit high per cycle.
- Backpressure: grant warp 2 with data 0xA5, then hold out_ready=0 for 3 cycles → out_valid=1, out_wid=2, out_data=0xA5 stable, req_ready=0 for 3 cycles. Raising out_ready accepts it, and the next grant is warp 3.
- Branch block: warp 1 issues a branch → br_pend=4'b0010. Warp 1 req_valid stays high but is skipped: grants go 2,3,0,2… Pulse br_valid, br_wid=1 → br_pend=0, and warp 1 is granted in its next round-robin slot after the clear cycle.
- Simultaneous: warp 0 branch grant in the same cycle as br_valid for warp 3 (pending) → br_pend becomes 4'b0001. A stray br_valid for non-pending warp 2 leaves br_pend unchanged.
- Single warp streaming: only warp 0 valid, is_br=0, out_ready=1 → warp 0 granted every cycle, out_valid continuously 1. Dropping req_valid → out_valid=0 one cycle later, and idle=1.
- Reset mid-operation: out_valid=1 held by out_ready=0 and br_pend=4'b1000, then assert reset_n=0 asynchronously between edges → out_valid=0 and br_pend=0 immediately. After release with all warps valid, the first grant is warp 0.
